// File: rtl/OpCode_pkg.sv
// Shared opcode definitions for the multi-cycle RISC-V core.
// Legal-opcode check used by the fetch stage and the control FSM.
package OpCode_pkg;

    typedef enum logic [6:0] {
        LW_OP  = 7'b0000011,
        SW_OP  = 7'b0100011,
        R_OP   = 7'b0110011,
        I_OP   = 7'b0010011,
        JAL_OP = 7'b1101111,
        BEQ_OP = 7'b1100011
    } OpCode_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic bit is_legal_opcode(logic [6:0] op);
        unique case (1'b1)
            op == LW_OP:  return 1'b1;
            op == SW_OP:  return 1'b1;
            op == R_OP:   return 1'b1;
            op == I_OP:   return 1'b1;
            op == JAL_OP: return 1'b1;
            op == BEQ_OP: return 1'b1;
            default:      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/en_flop.sv
// Register with enable and synchronous active-high reset value.
// Reset dominates the enable.
module en_flop #(
    parameter int          W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_En,
    input  logic [W-1:0] i_D,
    output logic [W-1:0] o_Q
);

    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            o_Q <= RST_VAL;
        else if (i_En)
            o_Q <= i_D;
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC / IR stage of the multi-cycle core; flags illegal opcodes and bad PCs.
// Optional legal-fetch counter enabled by defining FETCH_PERF_CNT_EN.
import OpCode_pkg::*;

module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic            i_Stall,
    input  logic            i_PCUpdate,
    input  logic            i_Branch,
    input  logic            i_Zero,
    input  logic            i_IRWrite,
    input  logic [XLEN-1:0] i_Result,
    input  logic [XLEN-1:0] i_ReadData,
    output logic [XLEN-1:0] o_PC,
    output logic [XLEN-1:0] o_OldPC,
    output logic [XLEN-1:0] o_Instr,
    output OpCode_t         o_OpCode,
    output logic            o_Illegal,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     o_InstrCount,
`endif
    output logic            o_Misaligned
);

    logic pc_write;
    logic aligned;
    logic pc_en;
    logic ir_en;
    logic rd_legal;

    assign pc_write = i_PCUpdate | (i_Branch & i_Zero);
    assign aligned  = (i_Result[1:0] == 2'b00);
    assign pc_en    = ~i_Stall & pc_write & aligned;
    assign ir_en    = ~i_Stall & i_IRWrite;
    assign rd_legal = is_legal_opcode(i_ReadData[6:0]);

    en_flop #(.W(XLEN), .RST_VAL(RESET_PC)) u_pc (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_En    (pc_en),
        .i_D     (i_Result),
        .o_Q     (o_PC)
    );

    // OldPC takes the pre-update PC even when the PC is written this cycle
    en_flop #(.W(XLEN), .RST_VAL(RESET_PC)) u_old_pc (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_En    (ir_en),
        .i_D     (o_PC),
        .o_Q     (o_OldPC)
    );

    en_flop #(.W(XLEN), .RST_VAL(NOP_INSTR)) u_ir (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_En    (ir_en),
        .i_D     (i_ReadData),
        .o_Q     (o_Instr)
    );

    assign o_OpCode = OpCode_t'(o_Instr[6:0]);

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Illegal    <= 1'b0;
            o_Misaligned <= 1'b0;
        end else if (!i_Stall) begin
            if (i_IRWrite)
                o_Illegal <= ~rd_legal;
            if (pc_write && !aligned)
                o_Misaligned <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            o_InstrCount <= '0;
        else if (ir_en && rd_legal && o_InstrCount != 32'hFFFF_FFFF)
            o_InstrCount <= o_InstrCount + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit; counter checks need FETCH_PERF_CNT_EN.
// Each task drives one scenario and checks expected values inline.
import OpCode_pkg::*;

module tb_fetch_pc_unit;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b0;
    logic        i_Stall = 1'b0;
    logic        i_PCUpdate = 1'b0;
    logic        i_Branch = 1'b0;
    logic        i_Zero = 1'b0;
    logic        i_IRWrite = 1'b0;
    logic [31:0] i_Result = '0;
    logic [31:0] i_ReadData = '0;
    logic [31:0] o_PC;
    logic [31:0] o_OldPC;
    logic [31:0] o_Instr;
    OpCode_t     o_OpCode;
    logic        o_Illegal;
    logic        o_Misaligned;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] o_InstrCount;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_Clk = ~i_Clk;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_Stall      (i_Stall),
        .i_PCUpdate   (i_PCUpdate),
        .i_Branch     (i_Branch),
        .i_Zero       (i_Zero),
        .i_IRWrite    (i_IRWrite),
        .i_Result     (i_Result),
        .i_ReadData   (i_ReadData),
        .o_PC         (o_PC),
        .o_OldPC      (o_OldPC),
        .o_Instr      (o_Instr),
        .o_OpCode     (o_OpCode),
        .o_Illegal    (o_Illegal),
`ifdef FETCH_PERF_CNT_EN
        .o_InstrCount (o_InstrCount),
`endif
        .o_Misaligned (o_Misaligned)
    );

    task automatic step();
        @(posedge i_Clk);
        #1;
        i_Reset    = 1'b0;
        i_Stall    = 1'b0;
        i_PCUpdate = 1'b0;
        i_Branch   = 1'b0;
        i_Zero     = 1'b0;
        i_IRWrite  = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        i_PCUpdate = 1'b1;
        i_Result   = v;
        step();
    endtask

    task automatic test_reset();
        i_Reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (o_PC !== 32'h0) begin
            n_bad++; $display("FAIL reset_pc got %h want %h", o_PC, 32'h0);
        end
        n_cmp++;
        if (o_OldPC !== 32'h0) begin
            n_bad++; $display("FAIL reset_oldpc got %h want %h", o_OldPC, 32'h0);
        end
        n_cmp++;
        if (o_Instr !== 32'h13) begin
            n_bad++; $display("FAIL reset_instr got %h want %h", o_Instr, 32'h13);
        end
        n_cmp++;
        if (o_OpCode !== I_OP) begin
            n_bad++; $display("FAIL reset_opcode got %b want %b", o_OpCode, I_OP);
        end
        n_cmp++;
        if (o_Illegal !== 1'b0 || o_Misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags got %b%b want 00", o_Illegal, o_Misaligned);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (o_InstrCount !== 32'd0) begin
            n_bad++; $display("FAIL reset_count got %0d want 0", o_InstrCount);
        end
`endif
    endtask

    task automatic test_fetch();
        set_pc(32'h10);
        i_IRWrite  = 1'b1;
        i_PCUpdate = 1'b1;
        i_Result   = 32'h14;
        i_ReadData = 32'h00A0_0093;
        step();
        n_cmp++;
        if (o_PC !== 32'h14) begin
            n_bad++; $display("FAIL fetch_pc got %h want %h", o_PC, 32'h14);
        end
        n_cmp++;
        if (o_OldPC !== 32'h10) begin
            n_bad++; $display("FAIL fetch_oldpc got %h want %h", o_OldPC, 32'h10);
        end
        n_cmp++;
        if (o_Instr !== 32'h00A0_0093) begin
            n_bad++; $display("FAIL fetch_instr got %h want %h", o_Instr, 32'h00A00093);
        end
        n_cmp++;
        if (o_OpCode !== I_OP) begin
            n_bad++; $display("FAIL fetch_opcode got %b want %b", o_OpCode, I_OP);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (o_InstrCount !== 32'd1) begin
            n_bad++; $display("FAIL fetch_count got %0d want 1", o_InstrCount);
        end
`endif
    endtask

    task automatic test_branch();
        i_Branch = 1'b1;
        i_Zero   = 1'b0;
        i_Result = 32'h40;
        step();
        n_cmp++;
        if (o_PC !== 32'h14) begin
            n_bad++; $display("FAIL beq_not_taken got %h want %h", o_PC, 32'h14);
        end
        i_Branch = 1'b1;
        i_Zero   = 1'b1;
        i_Result = 32'h40;
        step();
        n_cmp++;
        if (o_PC !== 32'h40) begin
            n_bad++; $display("FAIL beq_taken got %h want %h", o_PC, 32'h40);
        end
    endtask

    task automatic test_misaligned();
        set_pc(32'h42);
        n_cmp++;
        if (o_PC !== 32'h40 || o_Misaligned !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign got pc=%h mis=%b want pc=40 mis=1", o_PC, o_Misaligned);
        end
        set_pc(32'h44);
        n_cmp++;
        if (o_PC !== 32'h44 || o_Misaligned !== 1'b1) begin
            n_bad++;
            $display("FAIL misalign_sticky got pc=%h mis=%b want pc=44 mis=1", o_PC, o_Misaligned);
        end
    endtask

    task automatic test_illegal();
        i_IRWrite  = 1'b1;
        i_ReadData = 32'h0000_007F;
        step();
        n_cmp++;
        if (o_Illegal !== 1'b1 || o_OldPC !== 32'h44) begin
            n_bad++;
            $display("FAIL illegal_set got ill=%b old=%h want ill=1 old=44", o_Illegal, o_OldPC);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (o_InstrCount !== 32'd1) begin
            n_bad++; $display("FAIL illegal_count got %0d want 1", o_InstrCount);
        end
`endif
        step();
        n_cmp++;
        if (o_Illegal !== 1'b1) begin
            n_bad++; $display("FAIL illegal_hold got %b want 1", o_Illegal);
        end
        i_IRWrite  = 1'b1;
        i_ReadData = 32'h0000_0033;
        step();
        n_cmp++;
        if (o_Illegal !== 1'b0 || o_OpCode !== R_OP) begin
            n_bad++;
            $display("FAIL illegal_clear got ill=%b op=%b want ill=0 op=%b", o_Illegal, o_OpCode, R_OP);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (o_InstrCount !== 32'd2) begin
            n_bad++; $display("FAIL legal_count got %0d want 2", o_InstrCount);
        end
`endif
    endtask

    task automatic test_dual_write();
        i_Branch   = 1'b1;
        i_Zero     = 1'b1;
        i_PCUpdate = 1'b1;
        i_Result   = 32'h80;
        step();
        n_cmp++;
        if (o_PC !== 32'h80) begin
            n_bad++; $display("FAIL branch_and_update got %h want %h", o_PC, 32'h80);
        end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        set_pc(32'h0);
        n_cmp++;
        if (o_PC !== 32'h0) begin
            n_bad++; $display("FAIL pc_wrap got %h want %h", o_PC, 32'h0);
        end
    endtask

    task automatic test_stall();
        i_Stall    = 1'b1;
        i_IRWrite  = 1'b1;
        i_PCUpdate = 1'b1;
        i_Result   = 32'h100;
        i_ReadData = 32'h0000_007F;
        step();
        n_cmp++;
        if (o_PC !== 32'h0 || o_Instr !== 32'h33 || o_OldPC !== 32'h44) begin
            n_bad++;
            $display("FAIL stall_hold got pc=%h ir=%h old=%h want pc=0 ir=33 old=44",
                     o_PC, o_Instr, o_OldPC);
        end
        n_cmp++;
        if (o_Illegal !== 1'b0) begin
            n_bad++; $display("FAIL stall_illegal got %b want 0", o_Illegal);
        end
        step();
        n_cmp++;
        if (o_PC !== 32'h0) begin
            n_bad++; $display("FAIL stall_no_replay got %h want %h", o_PC, 32'h0);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (o_InstrCount !== 32'd2) begin
            n_bad++; $display("FAIL stall_count got %0d want 2", o_InstrCount);
        end
`endif
    endtask

    task automatic test_stall_reset();
        set_pc(32'h20);
        i_IRWrite  = 1'b1;
        i_ReadData = 32'h0000_007F;
        step();
        i_Reset    = 1'b1;
        i_Stall    = 1'b1;
        i_PCUpdate = 1'b1;
        i_Result   = 32'h50;
        step();
        n_cmp++;
        if (o_PC !== 32'h0 || o_OldPC !== 32'h0 || o_Instr !== 32'h13) begin
            n_bad++;
            $display("FAIL stall_reset_regs got pc=%h old=%h ir=%h want 0 0 13",
                     o_PC, o_OldPC, o_Instr);
        end
        n_cmp++;
        if (o_Illegal !== 1'b0 || o_Misaligned !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_reset_flags got %b%b want 00", o_Illegal, o_Misaligned);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++;
        if (o_InstrCount !== 32'd0) begin
            n_bad++; $display("FAIL stall_reset_count got %0d want 0", o_InstrCount);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_branch();
        test_misaligned();
        test_illegal();
        test_dual_write();
        test_wrap();
        test_stall();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
